// File: rtl/alu_acc_seq.sv
// alu_acc_seq: accumulator ALU with handshake; the optional shift-add multiplier (opcode 110)
// is built only when ALU_MULT_EN is defined, otherwise 110 pulses IllegalOp.
module alu_acc_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             op_valid_i,
  input  logic [2:0]       opcode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             op_ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ac_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             illegal_op_o
);
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] ac_q, ac_d, alu_res;
  logic             carry_q, carry_d, done_q, done_d, alu_carry, accept;
  logic [WIDTH:0]   sum_add, sum_inc;
  assign accept  = op_valid_i && op_ready_o;
  assign sum_add = {1'b0, ac_q} + {1'b0, data_i};
  assign sum_inc = {1'b0, ac_q} + (WIDTH+1)'(1);
  assign ac_o    = ac_q;
  assign carry_o = carry_q;
  assign zero_o  = ac_q == '0;
  assign done_o  = done_q;
  always_comb begin
    alu_res   = ac_q;
    alu_carry = 1'b0;
    case (opcode_i)
      3'b000:  alu_res = '0;
      3'b001:  alu_res = ac_q >> 1;
      3'b010:  {alu_carry, alu_res} = sum_add;
      3'b011:  {alu_carry, alu_res} = sum_inc;
      3'b100:  alu_res = {ac_q[H-1:0], ac_q[WIDTH-1:H]};
      3'b101:  alu_res = ~ac_q;
      3'b111:  alu_res = data_i;
      default: alu_carry = carry_q;
    endcase
  end
`ifdef ALU_MULT_EN
  localparam int CW = $clog2(H) + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [H-1:0]     mplier_q, mplier_d;
  assign op_ready_o   = state_q == IDLE;
  assign illegal_op_o = 1'b0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    ac_d     = ac_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (accept && opcode_i == 3'b110) begin
        state_d  = MUL;
        cnt_d    = '0;
        mcand_d  = {{H{1'b0}}, data_i[WIDTH-1:H]};
        mplier_d = ac_q[WIDTH-1:H];
        prod_d   = '0;
      end else if (accept) begin
        ac_d    = alu_res;
        carry_d = alu_carry;
        done_d  = 1'b1;
      end
    end else begin
      // one multiplier bit per edge; AC is only written on the final step
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(H - 1)) begin
        state_d = IDLE;
        ac_d    = prod_d;
        carry_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end
`else
  logic illegal_q, illegal_d;
  assign op_ready_o   = 1'b1;
  assign illegal_op_o = illegal_q;
  always_comb begin
    ac_d      = accept ? alu_res : ac_q;
    carry_d   = accept ? alu_carry : carry_q;
    done_d    = accept;
    illegal_d = accept && opcode_i == 3'b110;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
  end
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ac_q    <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ac_q    <= ac_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: vector table, hand sequences and random ops against an arithmetic reference model.
module tb_alu_acc_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [15:0] data = 16'd0;
  logic        op_ready, done, carry, zero, illegal;
  logic [15:0] ac;
  int n_tests = 0;
  int n_fail = 0;
  int m_ac = 0, m_carry = 0, m_busy = 0, m_pend = 0, m_done = 0, m_ill = 0;
`ifdef ALU_MULT_EN
  localparam bit MULT = 1'b1;
`else
  localparam bit MULT = 1'b0;
`endif

  alu_acc_seq #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .op_valid_i(op_valid), .opcode_i(opcode), .data_i(data),
    .op_ready_o(op_ready), .done_o(done), .ac_o(ac), .carry_o(carry), .zero_o(zero),
    .illegal_op_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d;
    logic [15:0] ac;
    logic        c;
  } vec_t;
  vec_t tbl [0:8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ac = 0; m_carry = 0; m_busy = 0; m_done = 0; m_ill = 0;
  endtask

  task automatic check_all();
    chk("ac", 32'(ac), 32'(m_ac));
    chk("carry", 32'(carry), 32'(m_carry));
    chk("zero", 32'(zero), 32'(m_ac == 0));
    chk("done", 32'(done), 32'(m_done));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("ready", 32'(op_ready), 32'(m_busy == 0));
  endtask

  // one clock: drive inputs, advance the model, compare every output just after the edge
  task automatic cyc(input logic v, input logic [2:0] op, input logic [15:0] d);
    int s;
    op_valid = v; opcode = op; data = d;
    @(posedge clk);
    m_done = 0; m_ill = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ac = m_pend; m_carry = 0; m_done = 1;
      end
    end else if (v) begin
      m_done = 1;
      case (op)
        3'd0: begin m_ac = 0; m_carry = 0; end
        3'd1: begin m_ac = m_ac / 2; m_carry = 0; end
        3'd2: begin s = m_ac + int'(d); m_carry = s / 65536; m_ac = s % 65536; end
        3'd3: begin s = m_ac + 1; m_carry = s / 65536; m_ac = s % 65536; end
        3'd4: begin m_ac = (m_ac % 256) * 256 + m_ac / 256; m_carry = 0; end
        3'd5: begin m_ac = 65535 - m_ac; m_carry = 0; end
        3'd7: begin m_ac = int'(d); m_carry = 0; end
        default: begin
          if (MULT) begin
            m_pend = (int'(d) / 256) * (m_ac / 256);
            m_busy = 8; m_done = 0;
          end else m_ill = 1;
        end
      endcase
    end
    #1;
    check_all();
  endtask

  initial begin
    tbl = '{
      '{3'd7, 16'h1234, 16'h1234, 1'b0},
      '{3'd4, 16'h0000, 16'h3412, 1'b0},
      '{3'd5, 16'h0000, 16'hCBED, 1'b0},
      '{3'd7, 16'hFFFF, 16'hFFFF, 1'b0},
      '{3'd2, 16'h0001, 16'h0000, 1'b1},
      '{3'd7, 16'hFFFF, 16'hFFFF, 1'b0},
      '{3'd3, 16'h0000, 16'h0000, 1'b1},
      '{3'd7, 16'h8001, 16'h8001, 1'b0},
      '{3'd1, 16'h0000, 16'h4000, 1'b0}
    };
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ac", 32'(ac), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_ready", 32'(op_ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) begin
      cyc(1'b1, tbl[i].op, tbl[i].d);
      chk("tbl_ac", 32'(ac), 32'(tbl[i].ac));
      chk("tbl_carry", 32'(carry), 32'(tbl[i].c));
    end
    cyc(1'b0, 3'd0, 16'h0);

    if (MULT) begin
      cyc(1'b1, 3'd7, 16'h0300);
      cyc(1'b1, 3'd6, 16'h0500);
      for (int i = 0; i < 8; i++) cyc(1'b1, 3'd7, 16'hDEAD);
      chk("mul_3x5", 32'(ac), 32'h000F);
      chk("mul_done", 32'(done), 32'h1);
      cyc(1'b0, 3'd0, 16'h0);
      cyc(1'b1, 3'd7, 16'hFF00);
      cyc(1'b1, 3'd6, 16'hFF00);
      for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 16'h0);
      chk("mul_ffxff", 32'(ac), 32'hFE01);
      cyc(1'b0, 3'd0, 16'h0);
      // reset pulse spanning E4 of a multiply
      cyc(1'b1, 3'd7, 16'h0300);
      cyc(1'b1, 3'd6, 16'h0500);
      for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 16'h0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("abort_ac", 32'(ac), 32'h0);
      @(posedge clk);
      #1;
      chk("abort_done", 32'(done), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1'b0, 3'd0, 16'h0);
    end else begin
      cyc(1'b1, 3'd7, 16'h00AA);
      cyc(1'b1, 3'd6, 16'h1111);
      chk("ill_ac", 32'(ac), 32'h00AA);
      chk("ill_pulse", 32'({done, illegal}), 32'h3);
      cyc(1'b0, 3'd0, 16'h0);
      chk("ill_end", 32'({done, illegal}), 32'h0);
    end

    for (int i = 0; i < 800; i++)
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
